// File: rtl/ysyx_2022040010_lsu.sv
// EX->SRAM load/store access unit; aligned load 3 cycles (accept, REQ, WAIT -> DONE), store 2.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, stall high meanwhile.
module ysyx_2022040010_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [1:0]  in_size,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_rdata,
    output logic [7:0]  out_sel,
    output logic        out_err,
    output logic        stall
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [63:0]     r_addr;
    logic [63:0]     r_wdata;
    logic [63:0]     r_rdata;
    logic [7:0]      r_sel;
    logic            r_load;
    logic            r_store;
    logic            r_err;

    logic [7:0]      w_sel;
    logic            w_mis;
    logic            w_tmo;

    always_comb begin
        w_sel = 8'h00;
        w_mis = 1'b0;
        case (in_size)
            2'd0: w_sel = 8'h01 << in_addr[2:0];
            2'd1: begin
                w_sel = 8'h03 << in_addr[2:0];
                w_mis = in_addr[0];
            end
            2'd2: begin
                w_sel = 8'h0F << in_addr[2:0];
                w_mis = (in_addr[1:0] != 2'b00);
            end
            default: begin
                w_sel = 8'hFF;
                w_mis = (in_addr[2:0] != 3'b000);
            end
        endcase
    end

    // A completion in the same cycle as the last allowed count wins over the timeout.
    assign w_tmo = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_sel   <= '0;
            r_load  <= 1'b0;
            r_store <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_addr  <= {in_addr[63:3], 3'b000};
                        r_wdata <= in_wdata << {in_addr[2:0], 3'b000};
                        r_load  <= in_load;
                        r_store <= in_store;
                        r_rdata <= '0;
                        r_cnt   <= '0;
                        if (w_mis || (in_load && in_store)) begin
                            r_sel   <= 8'h00;
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_sel   <= w_sel;
                            r_err   <= 1'b0;
                            r_state <= (in_load || in_store) ? S_REQ : S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (mem_gnt && (r_store || mem_rvalid)) begin
                        if (!r_store) r_rdata <= mem_rdata;
                        r_state <= S_DONE;
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_sel   <= 8'h00;
                        r_state <= S_DONE;
                    end else if (mem_gnt) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (mem_rvalid) begin
                        r_rdata <= mem_rdata;
                        r_state <= S_DONE;
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_sel   <= 8'h00;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    if (out_ready) r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign stall     = (r_state != S_IDLE);
    assign mem_req   = (r_state == S_REQ);
    assign mem_we    = mem_req && r_store;
    assign mem_wmask = mem_we ? r_sel : 8'h00;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign out_valid = (r_state == S_DONE);
    assign out_rdata = out_valid ? r_rdata : 64'h0;
    assign out_sel   = out_valid ? r_sel : 8'h00;
    assign out_err   = out_valid && r_err;
endmodule

// File: tb/tb_ysyx_2022040010_lsu.sv
// Randomized and directed bench for ysyx_2022040010_lsu against a per-transaction outcome model.
module tb_ysyx_2022040010_lsu;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_load = 1'b0, in_store = 1'b0;
    logic [1:0]  in_size = '0;
    logic [63:0] in_addr = '0, in_wdata = '0;
    logic        in_ready, stall;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        out_valid, out_err;
    logic        out_ready = 1'b0;
    logic [63:0] out_rdata;
    logic [7:0]  out_sel;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_2022040010_lsu #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
        .in_size(in_size), .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_sel(out_sel),
        .out_err(out_err), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // g: REQ cycles with gnt low before gnt; r: cycles from gnt to rvalid (loads).
    task automatic run_op(input bit ld, input bit st, input logic [1:0] sz,
                          input logic [63:0] a, input logic [63:0] wd,
                          input int g, input int r, input int rdy_dly);
        logic [63:0] rd, exp_rd, exp_wd, snap_rd;
        logic [15:0] m;
        logic [7:0]  sel, exp_sel, exp_mask;
        int bytes, off, c, c_eff, exp_k, k;
        bit mis, imm_err, noop, tmo, exp_err, in_req;

        rd      = {$urandom, $urandom};
        bytes   = 1 << sz;
        off     = int'(a[2:0]);
        mis     = (off % bytes) != 0;
        imm_err = mis || (ld && st);
        noop    = !ld && !st;
        c       = st ? g : g + r;
        tmo     = !imm_err && !noop && (c > TMO - 1);
        c_eff   = tmo ? TMO - 1 : c;
        exp_k   = (imm_err || noop) ? 0 : c_eff + 1;
        m       = ((16'd1 << bytes) - 16'd1) << off;
        sel     = m[7:0];
        exp_err = imm_err || tmo;
        exp_sel = exp_err ? 8'h00 : sel;
        exp_rd  = (ld && !exp_err) ? rd : 64'h0;
        exp_wd  = wd << (8 * off);
        exp_mask = st ? sel : 8'h00;

        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_stall", 64'(stall), 64'd0);
        in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz; in_addr = a; in_wdata = wd;
        step();
        in_valid = 1'b0; in_addr = {$urandom, $urandom}; in_wdata = {$urandom, $urandom};
        in_load = 1'(ld ^ 1'b1); in_store = 1'($urandom);

        k = 0;
        while (!out_valid && k <= 40) begin
            in_req = (k <= g) && (k < exp_k);
            chk("mem_req", 64'(mem_req), 64'(in_req));
            chk("busy_stall", 64'(stall), 64'd1);
            if (in_req) begin
                chk("mem_addr", mem_addr, {a[63:3], 3'b000});
                chk("mem_we", 64'(mem_we), 64'(st));
                chk("mem_wmask", 64'(mem_wmask), 64'(exp_mask));
                if (st) chk("mem_wdata", mem_wdata, exp_wd);
            end
            mem_gnt    = (k == g);
            mem_rvalid = ld && (k == g + r);
            mem_rdata  = mem_rvalid ? rd : {$urandom, $urandom};
            step();
            k++;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;

        chk("latency", 64'(k), 64'(exp_k));
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("out_rdata", out_rdata, exp_rd);
        chk("out_sel", 64'(out_sel), 64'(exp_sel));
        chk("out_err", 64'(out_err), 64'(exp_err));

        // Hold in DONE while throwing spurious responses and grants at the unit.
        for (int i = 0; i < rdy_dly; i++) begin
            snap_rd    = {$urandom, $urandom};
            mem_rvalid = 1'b1;
            mem_rdata  = snap_rd;
            mem_gnt    = 1'($urandom);
            step();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_rdata", out_rdata, exp_rd);
            chk("hold_sel", 64'(out_sel), 64'(exp_sel));
            chk("hold_err", 64'(out_err), 64'(exp_err));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_stall", 64'(stall), 64'd1);
            chk("hold_mem_req", 64'(mem_req), 64'd0);
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_mem_req", 64'(mem_req), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_mem_wmask"}, 64'(mem_wmask), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_err"}, 64'(out_err), 64'd0);
        chk({tag, "_out_rdata"}, out_rdata, 64'd0);
        chk({tag, "_out_sel"}, 64'(out_sel), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_stall"}, 64'(stall), 64'd0);
    endtask

    initial begin
        logic [63:0] a;
        logic [1:0]  sz;
        int          pick;
        bit          ld, st;

        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        step();

        // Doubleword load, immediate gnt, rvalid the next cycle.
        run_op(1'b1, 1'b0, 2'd3, 64'h0000_0000_8000_0010, 64'h0, 0, 1, 0);
        // Byte store with gnt held off 3 cycles.
        run_op(1'b0, 1'b1, 2'd0, 64'h0000_0000_8000_0005, 64'hAB, 3, 0, 1);
        // Misaligned word load.
        run_op(1'b1, 1'b0, 2'd2, 64'h0000_0000_8000_0006, 64'h0, 0, 0, 0);
        // Load timing out in WAIT, then late rvalid during DONE hold.
        run_op(1'b1, 1'b0, 2'd3, 64'h0000_0000_8000_0020, 64'h0, 0, 20, 2);
        // Result held with out_ready low for 5 cycles.
        run_op(1'b1, 1'b0, 2'd1, 64'h0000_0000_8000_0102, 64'h0, 1, 1, 5);
        // No-op and load+store conflict.
        run_op(1'b0, 1'b0, 2'd2, 64'h0000_0000_8000_0004, 64'h0, 0, 0, 1);
        run_op(1'b1, 1'b1, 2'd0, 64'h0000_0000_8000_0001, 64'h5, 0, 0, 0);

        // Asynchronous reset while a load sits in WAIT.
        in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_size = 2'd3;
        in_addr = 64'h0000_0000_8000_0040;
        step();
        in_valid = 1'b0;
        chk("rst_pre_req", 64'(mem_req), 64'd1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("rst_wait_req", 64'(mem_req), 64'd0);
        chk("rst_wait_stall", 64'(stall), 64'd1);
        #1 rst = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b1;
        step();
        run_op(1'b1, 1'b0, 2'd2, 64'h0000_0000_8000_0044, 64'h0, 0, 1, 0);

        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(0, 9);
            ld = (pick == 1) || (pick >= 2 && pick <= 5);
            st = (pick == 1) || (pick >= 6);
            sz = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            run_op(ld, st, sz, a, {$urandom, $urandom},
                   $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
